// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter that grants one shared memory port to NUM_CH burst requesters,
// issues one address per cycle and routes read data back after a fixed latency.
module mem_burst_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 6,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_beat,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     mem_en,
  output logic                     mem_rw,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     owner_q, owner_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [LEN_W-1:0]    rcnt_q, rcnt_d;
  logic                rw_q, rw_d;
  logic                wdone_q, wdone_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;

  logic                found;
  logic [CH_W-1:0]     pick;
  logic [LEN_W-1:0]    pickLen;
  int                  idx;
  logic                issueRd;
  logic                rvalidNow;
  logic                readLast;
  logic                lastBeat;
  logic [NUM_CH-1:0]   ownerOh;

  // Round-robin search starting at rr, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
    pickLen = ch_len[pick*LEN_W +: LEN_W];
  end

  assign issueRd   = (state_q == BURST) && rw_q;
  assign rvalidNow = vpipe_q[RD_LAT-1] && (state_q != IDLE);
  assign lastBeat  = (beat_q == len_q - LEN_W'(1));
  assign readLast  = (state_q == DRAIN) && vpipe_q[RD_LAT-1] && (rcnt_q == len_q - LEN_W'(1));
  assign ownerOh   = NUM_CH'(1) << owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      rcnt_q  <= '0;
      rw_q    <= 1'b0;
      wdone_q <= 1'b0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      rcnt_q  <= rcnt_d;
      rw_q    <= rw_d;
      wdone_q <= wdone_d;
      vpipe_q <= vpipe_d;
    end
  end

  // The burst parameters are captured at grant so the owner may change its inputs freely afterwards.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rw_d    = rw_q;
    wdone_d = 1'b0;
    rcnt_d  = rvalidNow ? rcnt_q + LEN_W'(1) : rcnt_q;
    vpipe_d = (vpipe_q << 1) | RD_LAT'(issueRd);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          base_d  = ch_addr[pick*ADDR_W +: ADDR_W];
          len_d   = (pickLen == '0) ? LEN_W'(1) : pickLen;
          rw_d    = ch_rw[pick];
          beat_d  = '0;
          rcnt_d  = '0;
          rr_d    = (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + CH_W'(1);
          state_d = BURST;
        end
      end
      BURST: begin
        beat_d = beat_q + LEN_W'(1);
        if (lastBeat) begin
          if (rw_q) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            wdone_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (readLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_grant  = '0;
    ch_beat   = '0;
    ch_rvalid = '0;
    ch_done   = '0;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = mem_rdata;
    if (state_q != IDLE) ch_grant = ownerOh;
    if (rvalidNow) ch_rvalid = ownerOh;
    if (wdone_q || readLast) ch_done = ownerOh;
    if (state_q == BURST) begin
      ch_beat   = ownerOh;
      mem_en    = 1'b1;
      mem_rw    = rw_q;
      mem_addr  = base_q + ADDR_W'(beat_q);
      mem_wdata = ch_wdata[owner_q*DATA_W +: DATA_W];
    end
  end

endmodule
